// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: 640x480@60 raster scan counters, sync generation and
// registered RGB444 pixel compositor for the VGA connector.
// Optional feature macro: VGA_SCAN_DIV_EN (clk/4 pixel strobe from 100 MHz).
// Ports: clk, rst_n (async, active low), disp (renderer hit for x,y),
//        x/y (scan position), video_on (active area, renderer enable),
//        hsync/vsync (active low, registered), rgb (registered RGB444),
//        frame_tick (one-clk pulse on the frame wrap edge).
module vga_scan_ctrl #(
   parameter int          H_ACTIVE = 640,
   parameter int          H_FP     = 16,
   parameter int          H_SYNC   = 96,
   parameter int          H_BP     = 48,
   parameter int          V_ACTIVE = 480,
   parameter int          V_FP     = 10,
   parameter int          V_SYNC   = 2,
   parameter int          V_BP     = 33,
   parameter logic [11:0] FG_COLOR = 12'hFFF,
   parameter logic [11:0] BG_COLOR = 12'h000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        disp,
   output logic [9:0]  x,
   output logic [9:0]  y,
   output logic        video_on,
   output logic        hsync,
   output logic        vsync,
   output logic [11:0] rgb,
   output logic        frame_tick
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [9:0]  h_cnt;
   logic [9:0]  v_cnt;
   logic        pix_tick;
   logic        h_last;
   logic        v_last;
   logic        hs_raw;
   logic        vs_raw;
   logic [11:0] rgb_next;

`ifdef VGA_SCAN_DIV_EN
   logic [1:0] div;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div <= 2'd0;
      end else begin
         div <= div + 2'd1;
      end
   end

   // Last clk of each 4-clk pixel period.
   assign pix_tick = (div == 2'd3);
`else
   assign pix_tick = 1'b1;
`endif

   always_comb begin
      h_last   = (h_cnt == H_LAST);
      v_last   = (v_cnt == V_LAST);
      video_on = (h_cnt < H_VIS) && (v_cnt < V_VIS);
      hs_raw   = !((h_cnt >= HS_BEG) && (h_cnt <= HS_END));
      vs_raw   = !((v_cnt >= VS_BEG) && (v_cnt <= VS_END));
      rgb_next = 12'h000;
      if (video_on) begin
         rgb_next = disp ? FG_COLOR : BG_COLOR;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt <= 10'd0;
         v_cnt <= 10'd0;
      end else if (pix_tick) begin
         if (h_last) begin
            h_cnt <= 10'd0;
            v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
         end else begin
            h_cnt <= h_cnt + 10'd1;
         end
      end
   end

   // Sync is registered alongside rgb so all three share one pixel of delay.
   // frame_tick updates every clk so it lasts exactly one clk, not one pixel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hsync      <= 1'b1;
         vsync      <= 1'b1;
         rgb        <= 12'h000;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= pix_tick && h_last && v_last;
         if (pix_tick) begin
            hsync <= hs_raw;
            vsync <= vs_raw;
            rgb   <= rgb_next;
         end
      end
   end

   assign x = h_cnt;
   assign y = v_cnt;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb_vga_scan_ctrl: directed scenario bench for vga_scan_ctrl.
// Full 800-pixel lines; a short 8-line frame keeps whole-frame runs small.
module tb_vga_scan_ctrl;

`ifdef VGA_SCAN_DIV_EN
   localparam int DIV = 4;
`else
   localparam int DIV = 1;
`endif

   localparam int HT = 800;
   localparam int VA = 4;
   localparam int VF = 1;
   localparam int VS = 2;
   localparam int VB = 1;
   localparam int VT = VA + VF + VS + VB;
   localparam logic [11:0] FG = 12'hC3F;
   localparam logic [11:0] BG = 12'h5A3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        disp = 1'b0;
   logic [9:0]  x;
   logic [9:0]  y;
   logic        video_on;
   logic        hsync;
   logic        vsync;
   logic [11:0] rgb;
   logic        frame_tick;

   int passed = 0;
   int total = 0;

   always #5 clk = ~clk;

   vga_scan_ctrl #(
      .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .FG_COLOR(FG), .BG_COLOR(BG)
   ) dut (
      .clk(clk), .rst_n(rst_n), .disp(disp),
      .x(x), .y(y), .video_on(video_on),
      .hsync(hsync), .vsync(vsync), .rgb(rgb),
      .frame_tick(frame_tick)
   );

   task automatic step_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic step_pix();
      repeat (DIV) step_clk();
   endtask

   task automatic goto(input int tx, input int ty);
      int n = 0;
      while (!(int'(x) == tx && int'(y) == ty) && n < 2 * HT * VT) begin
         step_pix();
         n++;
      end
      total++;
      if (!(int'(x) == tx && int'(y) == ty))
         $display("FAIL goto(%0d,%0d) timeout: at (%0d,%0d)", tx, ty, x, y);
      else
         passed++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      disp = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (x !== 10'd0 || y !== 10'd0)
         $display("FAIL rst_xy: got (%0d,%0d) want (0,0)", x, y);
      else passed++;
      total++;
      if (hsync !== 1'b1 || vsync !== 1'b1)
         $display("FAIL rst_sync: got h=%b v=%b want 1 1", hsync, vsync);
      else passed++;
      total++;
      if (rgb !== 12'h000)
         $display("FAIL rst_rgb: got %h want 000", rgb);
      else passed++;
      total++;
      if (frame_tick !== 1'b0)
         $display("FAIL rst_ft: got %b want 0", frame_tick);
      else passed++;
      total++;
      if (video_on !== 1'b1)
         $display("FAIL rst_video_on: got %b want 1", video_on);
      else passed++;
      disp = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++;
      if (x !== 10'd0)
         $display("FAIL rel_x0: got %0d want 0", x);
      else passed++;
      repeat (DIV - 1) step_clk();
      total++;
      if (x !== 10'd0)
         $display("FAIL rel_x_hold: got %0d want 0", x);
      else passed++;
      step_clk();
      total++;
      if (x !== 10'd1 || y !== 10'd0)
         $display("FAIL rel_first_tick: got (%0d,%0d) want (1,0)", x, y);
      else passed++;
      total++;
      if (rgb !== BG)
         $display("FAIL rel_rgb_bg: got %h want %h", rgb, BG);
      else passed++;
   endtask

   task automatic test_line();
      int lows = 0;
      int first_low = -1;
      int wrap_ok = 0;
      int px;
      int py;
      goto(0, 1);
      for (int i = 0; i < HT; i++) begin
         px = int'(x);
         py = int'(y);
         step_pix();
         if (hsync === 1'b0) begin
            lows++;
            if (first_low < 0) first_low = int'(x);
         end
         if (px == 799 && int'(x) == 0 && int'(y) == py + 1) wrap_ok = 1;
      end
      total++;
      if (lows != 96)
         $display("FAIL hsync_width: got %0d want 96", lows);
      else passed++;
      total++;
      if (first_low != 657)
         $display("FAIL hsync_start: seen at x=%0d want 657", first_low);
      else passed++;
      total++;
      if (wrap_ok != 1)
         $display("FAIL line_wrap: got %0d want 1 (799->0, y+1)", wrap_ok);
      else passed++;
   endtask

   task automatic test_single_pixel();
      int hits = 0;
      int hx = -1;
      int hy = -1;
      goto(0, 2);
      for (int i = 0; i < HT; i++) begin
         disp = (int'(x) == 100 && int'(y) == 2);
         step_pix();
         if (rgb === FG) begin
            hits++;
            hx = int'(x);
            hy = int'(y);
         end
      end
      disp = 1'b0;
      total++;
      if (hits != 1)
         $display("FAIL single_count: got %0d want 1", hits);
      else passed++;
      total++;
      if (hx != 101 || hy != 2)
         $display("FAIL single_pos: got (%0d,%0d) want (101,2)", hx, hy);
      else passed++;
   endtask

   task automatic test_reset_mid();
      int lows = 0;
      goto(700, 3);
      total++;
      if (hsync !== 1'b0)
         $display("FAIL mid_pre_hsync: got %b want 0", hsync);
      else passed++;
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (x !== 10'd0 || y !== 10'd0)
         $display("FAIL mid_rst_xy: got (%0d,%0d) want (0,0)", x, y);
      else passed++;
      total++;
      if (hsync !== 1'b1 || vsync !== 1'b1 || rgb !== 12'h000)
         $display("FAIL mid_rst_out: got h=%b v=%b rgb=%h want 1 1 000",
                  hsync, vsync, rgb);
      else passed++;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (x !== 10'd0 || frame_tick !== 1'b0)
         $display("FAIL mid_rst_hold: got x=%0d ft=%b want 0 0", x, frame_tick);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      step_pix();
      total++;
      if (x !== 10'd1 || y !== 10'd0)
         $display("FAIL mid_restart: got (%0d,%0d) want (1,0)", x, y);
      else passed++;
      for (int i = 1; i < 656; i++) begin
         step_pix();
         if (hsync !== 1'b1 || vsync !== 1'b1) lows++;
      end
      total++;
      if (lows != 0)
         $display("FAIL mid_no_runt: got %0d low pixels want 0", lows);
      else passed++;
   endtask

   task automatic test_frame();
      int vs_lows = 0;
      int vs_x = -1;
      int vs_y = -1;
      int ft_cnt = 0;
      int ft_bad = 0;
      int ft_first = -1;
      int ft_gap = -1;
      goto(799, VT - 1);
      for (int i = 0; i < HT * VT * DIV + DIV; i++) begin
         step_clk();
         if (vsync === 1'b0) begin
            vs_lows++;
            if (vs_x < 0) begin
               vs_x = int'(x);
               vs_y = int'(y);
            end
         end
         if (frame_tick === 1'b1) begin
            ft_cnt++;
            if (x !== 10'd0 || y !== 10'd0) ft_bad++;
            if (ft_first < 0) ft_first = i;
            else ft_gap = i - ft_first;
         end
      end
      total++;
      if (vs_lows != 1600 * DIV)
         $display("FAIL vsync_width: got %0d clks want %0d", vs_lows, 1600 * DIV);
      else passed++;
      total++;
      if (vs_x != 1 || vs_y != VA + VF)
         $display("FAIL vsync_start: got (%0d,%0d) want (1,%0d)", vs_x, vs_y, VA + VF);
      else passed++;
      total++;
      if (ft_cnt != 2)
         $display("FAIL ft_count: got %0d want 2", ft_cnt);
      else passed++;
      total++;
      if (ft_bad != 0)
         $display("FAIL ft_pos: got %0d pulses off (0,0) want 0", ft_bad);
      else passed++;
      total++;
      if (ft_gap != HT * VT * DIV)
         $display("FAIL ft_period: got %0d clks want %0d", ft_gap, HT * VT * DIV);
      else passed++;
   endtask

   task automatic test_colors();
      int bad = 0;
      int vo_bad = 0;
      int fg_cnt = 0;
      int px;
      int py;
      logic [11:0] exp_rgb;
      goto(0, 0);
      disp = 1'b1;
      for (int i = 0; i < HT * VT; i++) begin
         px = int'(x);
         py = int'(y);
         step_pix();
         exp_rgb = (px < 640 && py < VA) ? FG : 12'h000;
         if (rgb !== exp_rgb) bad++;
         if (rgb === FG) fg_cnt++;
         if (video_on !== (int'(x) < 640 && int'(y) < VA)) vo_bad++;
      end
      total++;
      if (bad != 0)
         $display("FAIL disp1_rgb: got %0d wrong pixels want 0", bad);
      else passed++;
      total++;
      if (fg_cnt != 640 * VA)
         $display("FAIL disp1_fg_count: got %0d want %0d", fg_cnt, 640 * VA);
      else passed++;
      total++;
      if (vo_bad != 0)
         $display("FAIL video_on: got %0d wrong pixels want 0", vo_bad);
      else passed++;
      disp = 1'b0;
      bad = 0;
      for (int i = 0; i < HT; i++) begin
         px = int'(x);
         py = int'(y);
         step_pix();
         exp_rgb = (px < 640 && py < VA) ? BG : 12'h000;
         if (rgb !== exp_rgb) bad++;
      end
      total++;
      if (bad != 0)
         $display("FAIL disp0_rgb: got %0d wrong pixels want 0", bad);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_line();
      test_single_pixel();
      test_reset_mid();
      test_frame();
      test_colors();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
